line_fill_fetcher: RTL and testbench
====================================

# line_fill_fetcher

Miss-path line-fill engine sitting directly downstream of the cache controller's miss-handling stage. On a fetch request it issues one word read per block word to the memory port and collects the in-order responses into a full-block buffer. It then presents the assembled line to the allocate path and holds it until that path acknowledges. It supplies the controller's `line_fill_valid` completion and consumes `line_allocated_ack`.

## Interface
- `DATA_WIDTH`, 32: memory word width in bits; multiple of 8.
- `BLOCK_SIZE`, 32: cache line size in bytes; power of two, ≥ DATA_WIDTH/8.
- `ADDRESS_WIDTH`, 32: byte address width.
- Derived (localparam): WORD_BYTES = DATA_WIDTH/8; WORDS = BLOCK_SIZE/WORD_BYTES; BYTE_OFF = $clog2(BLOCK_SIZE); IDX_W = max(1,$clog2(WORDS)).
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  clock, rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `fetch_request`  in  1  start a line fill; sampled only in IDLE.
- `fetch_address`  in  ADDRESS_WIDTH  byte address of the missing access.
- `fetch_busy`  out  1  high in every state except IDLE.
- `mem_req_valid`  out  1  word read request valid.
- `mem_req_ready`  in  1  memory accepts the request this cycle.
- `mem_req_addr`  out  ADDRESS_WIDTH  word-aligned read address.
- `mem_rsp_valid`  in  1  response word valid; in order; no backpressure.
- `mem_rsp_data`  in  DATA_WIDTH  response word.
- `mem_rsp_error`  in  1  response error, qualified by mem_rsp_valid.
- `line_fill_valid`  out  1  assembled line available.
- `line_fill_data`  out  WORDS*DATA_WIDTH  line; word i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `line_fill_address`  out  ADDRESS_WIDTH  block-aligned address of the line.
- `line_fill_error`  out  1  at least one response of this fill flagged error.
- `line_allocated_ack`  in  1  allocate path has consumed the line.

## Operation
- States: IDLE, ISSUE, COLLECT, DELIVER.
- IDLE: when `fetch_request` is high, latch block address (`fetch_address` with low BYTE_OFF bits cleared) and start word index. Clear issue count, response count, buffer and error flag. Go to ISSUE.
- ISSUE: `mem_req_valid`=1. `mem_req_addr` = block address + ((start + issue_cnt) mod WORDS)*WORD_BYTES. Index wraps within the block; it never carries into the block address. On `mem_req_valid && mem_req_ready`, issue_cnt++. After the WORDS-th accept, go to COLLECT, or to DELIVER if all responses have already arrived.
- Responses are accepted in both ISSUE and COLLECT. Each `mem_rsp_valid` writes `mem_rsp_data` into buffer slot (start + rsp_cnt) mod WORDS, increments rsp_cnt, and ORs `mem_rsp_error` into the error flag.
- COLLECT: when rsp_cnt reaches WORDS, go to DELIVER.
- DELIVER: `line_fill_valid`=1, with data, address and error stable. On `line_allocated_ack`, go to IDLE.
- Responses received in IDLE or DELIVER, or received after rsp_cnt==WORDS, are dropped. Buffer and counters are unchanged.
- `fetch_request` outside IDLE is ignored; it is not queued.
- An error does not abort the fill. All WORDS requests are still issued and collected.

## Timing
- Reset values: `mem_req_valid`=0, `mem_req_addr`=0, `fetch_busy`=0, `line_fill_valid`=0, `line_fill_data`=0, `line_fill_address`=0, `line_fill_error`=0. State IDLE, counters 0.
- `fetch_request` high in cycle 0 → `mem_req_valid` high in cycle 1.
- With `mem_req_ready` held high, one request is issued per cycle, so issue takes WORDS cycles.
- `line_fill_valid` rises the cycle after the clock edge that captures the last response.
- `line_allocated_ack` seen in cycle N → `line_fill_valid`=0 and `fetch_busy`=0 in cycle N+1. A new `fetch_request` is accepted in N+1 at the earliest.
- `mem_req_addr` is stable while `mem_req_valid`=1 and `mem_req_ready`=0.
- A response in the same cycle as the last request accept is counted.
- Reset asserted mid-fill returns all state and outputs to reset values immediately. Any in-flight responses are then dropped, as in IDLE.

## Configuration
- `LINE_FILL_CRITICAL_WORD_FIRST_EN` defined: start index = word index of `fetch_address` (bits [BYTE_OFF-1 : $clog2(WORD_BYTES)]). Requests go requested word first, then wrap.
- Not defined: start index is 0; requests go in ascending order from the block base.
- The buffer layout of `line_fill_data` is identical in both builds.

## Test plan
Defaults: 8 words.
- Fetch 0x0000_1234, ready always high, 2-cycle response latency, no macro → requests 0x1220, 0x1224, …, 0x123C on consecutive cycles. `line_fill_address`=0x1220, and word i equals the i-th response.
- Same stimulus with `LINE_FILL_CRITICAL_WORD_FIRST_EN` → request order 0x1234, 0x1238, 0x123C, 0x1220 … 0x1230. Response k lands in slot (5+k) mod 8.
- `mem_req_ready` low for 3 cycles on the 4th request → address 0x122C is held for 3 cycles with valid high; no request is duplicated or skipped.
- 3rd response carries error=1 → the fill still completes with all 8 words, and `line_fill_error`=1. The next fill without errors reports 0.
- `line_allocated_ack` delayed 5 cycles → `line_fill_valid` and data are held for those 5 cycles. A `fetch_request` during DELIVER is ignored; one in the cycle after the ack starts a new fill.
- `reset_n` pulsed low after 4 responses → all outputs return to 0. 4 further responses arriving in IDLE are dropped, and a following fill produces correct data.

Source files
------------

// File: rtl/line_fill_fetcher.sv
// Miss-path line fill: issues one read per block word, gathers in-order responses, holds the line until acknowledged.
// Optional build macro LINE_FILL_CRITICAL_WORD_FIRST_EN starts the fill at the missing word instead of the block base.
module line_fill_fetcher #(
  parameter int DATA_WIDTH    = 32,
  parameter int BLOCK_SIZE    = 32,
  parameter int ADDRESS_WIDTH = 32
) (
  input  logic                                       clk,
  input  logic                                       reset_n,
  input  logic                                       fetch_request,
  input  logic [ADDRESS_WIDTH-1:0]                   fetch_address,
  output logic                                       fetch_busy,
  output logic                                       mem_req_valid,
  input  logic                                       mem_req_ready,
  output logic [ADDRESS_WIDTH-1:0]                   mem_req_addr,
  input  logic                                       mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]                      mem_rsp_data,
  input  logic                                       mem_rsp_error,
  output logic                                       line_fill_valid,
  output logic [(BLOCK_SIZE/(DATA_WIDTH/8))*DATA_WIDTH-1:0] line_fill_data,
  output logic [ADDRESS_WIDTH-1:0]                   line_fill_address,
  output logic                                       line_fill_error,
  input  logic                                       line_allocated_ack
);

  localparam int WORD_BYTES = DATA_WIDTH / 8;
  localparam int WORDS      = BLOCK_SIZE / WORD_BYTES;
  localparam int BYTE_OFF   = $clog2(BLOCK_SIZE);
  localparam int IDX_W      = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int CNT_W      = $clog2(WORDS + 1);
  localparam int WB_LOG     = $clog2(WORD_BYTES);
  localparam logic [ADDRESS_WIDTH-1:0] OFF_MASK   = ADDRESS_WIDTH'((64'd1 << BYTE_OFF) - 64'd1);
  localparam logic [CNT_W-1:0]         LAST_ISSUE = CNT_W'(WORDS - 1);
  localparam logic [CNT_W-1:0]         FULL_CNT   = CNT_W'(WORDS);

  typedef enum logic [1:0] {IDLE, ISSUE, COLLECT, DELIVER} state_t;

  state_t                   state_reg;
  logic [ADDRESS_WIDTH-1:0] block_addr_reg;
  logic [IDX_W-1:0]         start_idx_reg;
  logic [CNT_W-1:0]         issue_cnt_reg;
  logic [CNT_W-1:0]         rsp_cnt_reg;
  logic [DATA_WIDTH-1:0]    line_buf_reg [WORDS];
  logic                     err_reg;
  logic                     req_valid_reg;
  logic [ADDRESS_WIDTH-1:0] req_addr_reg;
  logic                     busy_reg;
  logic                     fill_valid_reg;

  // Block is a power-of-two word count, so wrapping is a truncating add.
  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] s, input logic [CNT_W-1:0] c);
    if (WORDS == 1) return '0;
    return s + IDX_W'(c);
  endfunction

  function automatic logic [ADDRESS_WIDTH-1:0] word_addr(input logic [ADDRESS_WIDTH-1:0] blk,
                                                         input logic [IDX_W-1:0] idx);
    logic [ADDRESS_WIDTH-1:0] off;
    off = ADDRESS_WIDTH'(idx) << WB_LOG;
    return blk + off;
  endfunction

  logic [IDX_W-1:0]         start_idx;
  logic [ADDRESS_WIDTH-1:0] fetch_block;
  logic [CNT_W-1:0]         issue_cnt_next;
  logic [CNT_W-1:0]         rsp_cnt_next;
  logic [IDX_W-1:0]         rsp_slot;
  logic                     rsp_accept;
  logic                     rsp_done_next;

`ifdef LINE_FILL_CRITICAL_WORD_FIRST_EN
  assign start_idx = (WORDS == 1) ? '0 : IDX_W'(fetch_address >> WB_LOG);
`else
  assign start_idx = '0;
`endif

  assign fetch_block    = fetch_address & ~OFF_MASK;
  assign issue_cnt_next = issue_cnt_reg + CNT_W'(1);
  assign rsp_cnt_next   = rsp_cnt_reg + CNT_W'(1);
  assign rsp_slot       = wrap_idx(start_idx_reg, rsp_cnt_reg);
  assign rsp_accept     = mem_rsp_valid && (state_reg == ISSUE || state_reg == COLLECT)
                          && (rsp_cnt_reg != FULL_CNT);
  assign rsp_done_next  = (rsp_accept ? rsp_cnt_next : rsp_cnt_reg) == FULL_CNT;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      block_addr_reg <= '0;
      start_idx_reg  <= '0;
      issue_cnt_reg  <= '0;
      rsp_cnt_reg    <= '0;
      err_reg        <= 1'b0;
      req_valid_reg  <= 1'b0;
      req_addr_reg   <= '0;
      busy_reg       <= 1'b0;
      fill_valid_reg <= 1'b0;
      for (int i = 0; i < WORDS; i++) line_buf_reg[i] <= '0;
    end else begin
      if (rsp_accept) begin
        line_buf_reg[rsp_slot] <= mem_rsp_data;
        rsp_cnt_reg            <= rsp_cnt_next;
        err_reg                <= err_reg | mem_rsp_error;
      end
      case (state_reg)
        IDLE: begin
          if (fetch_request) begin
            block_addr_reg <= fetch_block;
            start_idx_reg  <= start_idx;
            issue_cnt_reg  <= '0;
            rsp_cnt_reg    <= '0;
            err_reg        <= 1'b0;
            req_valid_reg  <= 1'b1;
            req_addr_reg   <= word_addr(fetch_block, start_idx);
            busy_reg       <= 1'b1;
            state_reg      <= ISSUE;
            for (int i = 0; i < WORDS; i++) line_buf_reg[i] <= '0;
          end
        end
        ISSUE: begin
          if (mem_req_ready) begin
            issue_cnt_reg <= issue_cnt_next;
            if (issue_cnt_reg == LAST_ISSUE) begin
              req_valid_reg <= 1'b0;
              if (rsp_done_next) begin
                fill_valid_reg <= 1'b1;
                state_reg      <= DELIVER;
              end else begin
                state_reg <= COLLECT;
              end
            end else begin
              req_addr_reg <= word_addr(block_addr_reg, wrap_idx(start_idx_reg, issue_cnt_next));
            end
          end
        end
        COLLECT: begin
          if (rsp_done_next) begin
            fill_valid_reg <= 1'b1;
            state_reg      <= DELIVER;
          end
        end
        DELIVER: begin
          if (line_allocated_ack) begin
            fill_valid_reg <= 1'b0;
            busy_reg       <= 1'b0;
            state_reg      <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign fetch_busy        = busy_reg;
  assign mem_req_valid     = req_valid_reg;
  assign mem_req_addr      = req_addr_reg;
  assign line_fill_valid   = fill_valid_reg;
  assign line_fill_address = block_addr_reg;
  assign line_fill_error   = err_reg;

  for (genvar gi = 0; gi < WORDS; gi++) begin : g_pack
    assign line_fill_data[gi*DATA_WIDTH +: DATA_WIDTH] = line_buf_reg[gi];
  end

endmodule

// File: tb/tb_line_fill_fetcher.sv
// Directed bench for line_fill_fetcher: 8-word lines, 2-cycle memory latency model, one line per comparison failure.
module tb_line_fill_fetcher;
  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int WORDS = 8;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               fetch_request;
  logic [AW-1:0]      fetch_address;
  logic               fetch_busy;
  logic               mem_req_valid;
  logic               mem_req_ready;
  logic [AW-1:0]      mem_req_addr;
  logic               mem_rsp_valid;
  logic [DW-1:0]      mem_rsp_data;
  logic               mem_rsp_error;
  logic               line_fill_valid;
  logic [WORDS*DW-1:0] line_fill_data;
  logic [AW-1:0]      line_fill_address;
  logic               line_fill_error;
  logic               line_allocated_ack;

  line_fill_fetcher #(.DATA_WIDTH(DW), .BLOCK_SIZE(32), .ADDRESS_WIDTH(AW)) dut (
    .clk(clk), .reset_n(reset_n),
    .fetch_request(fetch_request), .fetch_address(fetch_address), .fetch_busy(fetch_busy),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_error(mem_rsp_error),
    .line_fill_valid(line_fill_valid), .line_fill_data(line_fill_data),
    .line_fill_address(line_fill_address), .line_fill_error(line_fill_error),
    .line_allocated_ack(line_allocated_ack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        err;
    logic        cnt_it;
  } rsp_t;

  rsp_t        rsp_q[$];
  logic [31:0] req_log[16];
  int          req_edge[16];
  int          req_n = 0, rsp_n = 0, last_rsp_edge = 0, fill_id = 0;
  int          err_idx = -1, stall_idx = -1, stall_left = 0, stall_cnt = 0, stall_bad = 0;
  logic [31:0] stall_addr = '0;

  function automatic logic [31:0] mk_data(input logic [31:0] a, input int id);
    logic [31:0] idv;
    idv = id;
    return a ^ 32'hC0DE_0000 ^ {idv[7:0], 24'h0};
  endfunction

  function automatic int start_of(input logic [31:0] a);
`ifdef LINE_FILL_CRITICAL_WORD_FIRST_EN
    return int'((a >> 2) & 32'h7);
`else
    return 0;
`endif
  endfunction

  function automatic logic [31:0] exp_req(input logic [31:0] a, input int n);
    logic [31:0] off;
    off = ((start_of(a) + n) % 8) * 4;
    return (a & 32'hFFFF_FFE0) + off;
  endfunction

  // Slot j always holds the word read from block base + 4*j, whatever the issue order.
  function automatic logic [255:0] exp_line(input logic [31:0] a);
    logic [255:0] v;
    v = '0;
    for (int j = 0; j < WORDS; j++) v[j*32 +: 32] = mk_data((a & 32'hFFFF_FFE0) + 32'(j * 4), fill_id);
    return v;
  endfunction

  // Ready driver: optional stall on a chosen request index.
  initial begin
    mem_req_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (stall_idx >= 0 && req_n == stall_idx && stall_left > 0) begin
        mem_req_ready = 1'b0;
        stall_left--;
      end else begin
        mem_req_ready = 1'b1;
      end
    end
  end

  // Memory model: logs accepted requests, answers each two edges after its accept.
  initial begin
    rsp_t r;
    rsp_t n;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    mem_rsp_error = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rsp_q.size() > 0 && rsp_q[0].due == cyc + 1) begin
        r = rsp_q.pop_front();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = r.data;
        mem_rsp_error = r.err;
        if (r.cnt_it) begin
          rsp_n++;
          last_rsp_edge = cyc + 1;
        end
      end else begin
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        mem_rsp_error = 1'b0;
      end
      if (mem_req_valid && mem_req_ready) begin
        if (req_n < 16) begin
          req_log[req_n]  = mem_req_addr;
          req_edge[req_n] = cyc + 1;
        end
        n.due    = cyc + 3;
        n.data   = mk_data(mem_req_addr, fill_id);
        n.err    = (req_n == err_idx);
        n.cnt_it = 1'b1;
        rsp_q.push_back(n);
        req_n++;
      end
      if (mem_req_valid && !mem_req_ready) begin
        stall_cnt++;
        if (mem_req_addr !== stall_addr) stall_bad++;
      end
    end
  end

  task automatic start_fill(input logic [31:0] a);
    fill_id++;
    req_n         = 0;
    rsp_n         = 0;
    stall_cnt     = 0;
    stall_bad     = 0;
    fetch_request = 1'b1;
    fetch_address = a;
    @(negedge clk);
    fetch_request = 1'b0;
    check("req_valid_cycle1", mem_req_valid, 1'b1);
    check("busy_cycle1", fetch_busy, 1'b1);
    check("req_addr_first", mem_req_addr, exp_req(a, 0));
  endtask

  task automatic wait_line(output int seen);
    for (int i = 0; i < 200 && line_fill_valid !== 1'b1; i++) @(negedge clk);
    check("fill_done", line_fill_valid, 1'b1);
    seen = cyc;
  endtask

  task automatic check_line(input logic [31:0] a, input logic exp_err);
    check("req_count", req_n, 8);
    for (int n = 0; n < WORDS; n++) check($sformatf("req_addr[%0d]", n), req_log[n], exp_req(a, n));
    check("line_addr", line_fill_address, a & 32'hFFFF_FFE0);
    check("line_data", line_fill_data, exp_line(a));
    check("line_err", line_fill_error, exp_err);
  endtask

  task automatic ack_line();
    line_allocated_ack = 1'b1;
    @(negedge clk);
    line_allocated_ack = 1'b0;
    check("ack_valid_low", line_fill_valid, 1'b0);
    check("ack_busy_low", fetch_busy, 1'b0);
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_busy"}, fetch_busy, 1'b0);
    check({pfx, "_req_valid"}, mem_req_valid, 1'b0);
    check({pfx, "_req_addr"}, mem_req_addr, '0);
    check({pfx, "_fill_valid"}, line_fill_valid, 1'b0);
    check({pfx, "_fill_data"}, line_fill_data, '0);
    check({pfx, "_fill_addr"}, line_fill_address, '0);
    check({pfx, "_fill_err"}, line_fill_error, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    reset_n            = 1'b0;
    fetch_request      = 1'b0;
    fetch_address      = '0;
    line_allocated_ack = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // Basic fill, ready always high: back-to-back requests, valid one cycle after last response edge.
    start_fill(32'h0000_1234);
    wait_line(seen);
    check("valid_latency", seen, last_rsp_edge);
    for (int n = 1; n < WORDS; n++) check($sformatf("req_spacing[%0d]", n), req_edge[n] - req_edge[0], n);
    check_line(32'h0000_1234, 1'b0);
    ack_line();

    // Three-cycle stall on the fourth request.
    stall_addr = exp_req(32'h0000_1234, 3);
    stall_idx  = 3;
    stall_left = 3;
    start_fill(32'h0000_1234);
    wait_line(seen);
    check("stall_cycles", stall_cnt, 3);
    check("stall_addr_held", stall_bad, 0);
    check_line(32'h0000_1234, 1'b0);
    ack_line();
    stall_idx = -1;

    // Error on the third response, then a clean fill.
    err_idx = 2;
    start_fill(32'h0000_5678);
    wait_line(seen);
    check_line(32'h0000_5678, 1'b1);
    ack_line();
    err_idx = -1;
    start_fill(32'h0000_5678);
    wait_line(seen);
    check_line(32'h0000_5678, 1'b0);
    ack_line();

    // Top-of-memory block, delayed ack with a stray fetch_request during DELIVER.
    start_fill(32'hFFFF_FFFC);
    wait_line(seen);
    check_line(32'hFFFF_FFFC, 1'b0);
    for (int k = 0; k < 5; k++) begin
      check("hold_valid", line_fill_valid, 1'b1);
      check("hold_data", line_fill_data, exp_line(32'hFFFF_FFFC));
      if (k == 1) begin
        fetch_request = 1'b1;
        fetch_address = 32'h0000_1000;
      end
      if (k == 2) fetch_request = 1'b0;
      @(negedge clk);
    end
    check("ignored_req_count", req_n, 8);
    check("ignored_req_addr", line_fill_address, 32'hFFFF_FFE0);
    ack_line();
    start_fill(32'h0000_1000);
    wait_line(seen);
    check_line(32'h0000_1000, 1'b0);
    ack_line();

    // Reset mid-fill, stray responses in IDLE, then a clean fill.
    start_fill(32'h0000_2468);
    for (int i = 0; i < 100 && rsp_n < 4; i++) @(negedge clk);
    check("mid_fill_rsp4", rsp_n >= 4, 1'b1);
    reset_n = 1'b0;
    rsp_q.delete();
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      rsp_t s;
      s.due    = cyc + k;
      s.data   = 32'hBAD0_0000 + 32'(k);
      s.err    = 1'b1;
      s.cnt_it = 1'b0;
      rsp_q.push_back(s);
    end
    repeat (6) @(negedge clk);
    check_all_zero("idle_drop");
    start_fill(32'h0000_2468);
    wait_line(seen);
    check_line(32'h0000_2468, 1'b0);
    ack_line();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
